// File: rtl/stopwatch_control_pkg.sv
// Shared types and helpers for the stopwatch run/pause/lap/clear sequencer.
// State encoding is fixed so the display/debug tooling can decode it.
package stopwatch_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // At most one button event acts per cycle, already priority-resolved.
    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_LAP   = 2'd2,
        EV_CLEAR = 2'd3
    } btn_evt_e;

    localparam int unsigned BCD_DIGIT_W = 4;

    function automatic int unsigned clks_per_tick(input int unsigned board_hz,
                                                  input int unsigned tick_hz);
        return (tick_hz == 0) ? 0 : board_hz / tick_hz;
    endfunction

    function automatic int unsigned prescaler_width(input int unsigned cpt);
        return (cpt > 1) ? $clog2(cpt) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_control_tick_prescaler.sv
// Free-running tick prescaler: counts 0..CLKS_PER_TICK-1 while enabled,
// holds while disabled, and is forced to zero by rst or zero.
module tick_prescaler
    import stopwatch_control_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic zero,
    output logic tick
);

    localparam int unsigned CNT_W = prescaler_width(CLKS_PER_TICK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zero) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational: the parent registers it into count_en.
    assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch sequencer: button edge detection, run/pause/lap/clear FSM,
// counter enable/clear pulses, direction latch and lap snapshot display.
module stopwatch_control
    import stopwatch_control_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS            = 4,
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned TICK_RATE_IN_HERTZ          = 100
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_stop,
    input  logic                                  lap,
    input  logic                                  clear,
    input  logic                                  up_down_in,
    input  logic [BCD_DIGIT_W*NUMBER_OF_DIGITS-1:0] live_number,
    output logic                                  count_en,
    output logic                                  count_clr,
    output logic                                  count_up_down,
    output logic [BCD_DIGIT_W*NUMBER_OF_DIGITS-1:0] shown_number,
    output logic                                  running,
    output logic                                  lap_active
);

    localparam int unsigned NUM_W         = BCD_DIGIT_W * NUMBER_OF_DIGITS;
    localparam int unsigned CLKS_PER_TICK =
        clks_per_tick(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_RATE_IN_HERTZ);

    if (CLKS_PER_TICK < 2) begin : g_bad_tick_rate
        $error("stopwatch_control: CLKS_PER_TICK must be >= 2");
    end

    sw_state_e        state_q;
    btn_evt_e         evt;
    logic             ss_prev_q;
    logic             lap_prev_q;
    logic             clr_prev_q;
    logic             rise_ss;
    logic             rise_lap;
    logic             rise_clr;
    logic             tick;
    logic             active;
    logic             count_en_q;
    logic             count_clr_q;
    logic             dir_q;
    logic [NUM_W-1:0] hold_q;
    logic [NUM_W-1:0] shown_q;

    assign rise_ss  = start_stop & ~ss_prev_q;
    assign rise_lap = lap        & ~lap_prev_q;
    assign rise_clr = clear      & ~clr_prev_q;

    // Highest-priority edge wins; lower edges in the same cycle are dropped.
    always_comb begin
        evt = EV_NONE;
        if (rise_ss) begin
            evt = EV_START;
        end else if (rise_lap) begin
            evt = EV_LAP;
        end else if (rise_clr) begin
            evt = EV_CLEAR;
        end
    end

    assign active = (state_q == ST_RUN) || (state_q == ST_LAP);

    tick_prescaler #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (active),
        .zero   (state_q == ST_IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ss_prev_q   <= 1'b1;
            lap_prev_q  <= 1'b1;
            clr_prev_q  <= 1'b1;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            dir_q       <= 1'b1;
            hold_q      <= '0;
            shown_q     <= '0;
        end else begin
            ss_prev_q   <= start_stop;
            lap_prev_q  <= lap;
            clr_prev_q  <= clear;
            // A start edge on the tick cycle pauses and swallows that tick.
            count_en_q  <= tick && (evt != EV_START);
            count_clr_q <= 1'b0;
            shown_q     <= (state_q == ST_LAP) ? hold_q : live_number;
            if (state_q == ST_IDLE) begin
                dir_q <= up_down_in;
            end

            case (state_q)
                ST_IDLE: begin
                    if (evt == EV_START) begin
                        state_q <= ST_RUN;
                    end else if (evt == EV_CLEAR) begin
                        count_clr_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (evt == EV_START) begin
                        state_q <= ST_PAUSE;
                    end else if (evt == EV_LAP) begin
                        state_q <= ST_LAP;
                        hold_q  <= live_number;
                    end
                end
                ST_LAP: begin
                    if (evt == EV_START) begin
                        state_q <= ST_PAUSE;
                    end else if (evt == EV_LAP) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (evt == EV_START) begin
                        state_q <= ST_RUN;
                    end else if (evt == EV_CLEAR) begin
                        state_q     <= ST_IDLE;
                        count_clr_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign count_en      = count_en_q;
    assign count_clr     = count_clr_q;
    assign count_up_down = dir_q;
    assign shown_number  = shown_q;
    assign running       = active;
    assign lap_active    = (state_q == ST_LAP);

endmodule

// File: tb/tb_stopwatch_control.sv
// Randomized + directed bench for stopwatch_control; a behavioural model
// predicts each cycle's outputs into a queue that a negedge monitor drains.
module tb_stopwatch_control;

    localparam int unsigned ND  = 4;
    localparam int unsigned NW  = 4 * ND;
    localparam int unsigned CPT = 400 / 100;

    typedef struct {
        logic          en;
        logic          clr;
        logic          ud;
        logic          run;
        logic          lapa;
        logic [NW-1:0] shown;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_stop;
    logic          lap;
    logic          clear;
    logic          up_down_in;
    logic [NW-1:0] live_number;
    logic          count_en;
    logic          count_clr;
    logic          count_up_down;
    logic [NW-1:0] shown_number;
    logic          running;
    logic          lap_active;

    stopwatch_control #(
        .NUMBER_OF_DIGITS            (ND),
        .BOARD_CLOCK_FREQUENCY_IN_HZ (400),
        .TICK_RATE_IN_HERTZ          (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_stop    (start_stop),
        .lap           (lap),
        .clear         (clear),
        .up_down_in    (up_down_in),
        .live_number   (live_number),
        .count_en      (count_en),
        .count_clr     (count_clr),
        .count_up_down (count_up_down),
        .shown_number  (shown_number),
        .running       (running),
        .lap_active    (lap_active)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Behavioural model: running / lapping / paused flags plus tick phase.
    bit          m_run, m_lap, m_paused, m_dir;
    int          m_phase;
    logic [NW-1:0] m_hold, m_shown;
    bit          p_ss, p_lp, p_cl;

    // Current input levels used by step().
    bit          lv_rst, lv_ss, lv_lp, lv_cl, lv_ud;
    logic [NW-1:0] lv_live;

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count_en",      NW'(count_en),      NW'(e.en));
            chk("count_clr",     NW'(count_clr),     NW'(e.clr));
            chk("count_up_down", NW'(count_up_down), NW'(e.ud));
            chk("running",       NW'(running),       NW'(e.run));
            chk("lap_active",    NW'(lap_active),    NW'(e.lapa));
            chk("shown_number",  shown_number,       e.shown);
        end
    end

    task automatic step();
        exp_t e;
        bit rs, rl, rc, go_s, go_l, go_c;
        rst = lv_rst; start_stop = lv_ss; lap = lv_lp; clear = lv_cl;
        up_down_in = lv_ud; live_number = lv_live;
        if (lv_rst) begin
            m_run = 0; m_lap = 0; m_paused = 0; m_phase = 0; m_dir = 1;
            m_hold = '0; m_shown = '0; p_ss = 1; p_lp = 1; p_cl = 1;
            e.en = 0; e.clr = 0;
        end else begin
            rs = lv_ss && !p_ss; rl = lv_lp && !p_lp; rc = lv_cl && !p_cl;
            p_ss = lv_ss; p_lp = lv_lp; p_cl = lv_cl;
            go_s = rs; go_l = rl && !rs; go_c = rc && !rs && !rl;
            e.en  = m_run && (m_phase == CPT - 1) && !go_s;
            e.clr = !m_run && go_c;
            m_shown = m_lap ? m_hold : lv_live;
            if (!m_run && !m_paused) m_dir = lv_ud;
            if (m_run) m_phase = (m_phase + 1) % CPT;
            else if (!m_paused) m_phase = 0;
            if (go_s) begin
                if (m_run) begin m_run = 0; m_lap = 0; m_paused = 1; end
                else begin m_run = 1; m_paused = 0; end
            end else if (go_l) begin
                if (m_lap) m_lap = 0;
                else if (m_run) begin m_lap = 1; m_hold = lv_live; end
            end else if (go_c && m_paused) begin
                m_paused = 0;
            end
        end
        e.ud = m_dir; e.run = m_run; e.lapa = m_lap; e.shown = m_shown;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            lv_live = lv_live + NW'(1);
        end
    endtask

    task automatic press_start();
        lv_ss = 1; cycles(2); lv_ss = 0; cycles(1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        lv_rst = 1; lv_ss = 1; lv_lp = 0; lv_cl = 0; lv_ud = 0; lv_live = '0;
        rst = 1; start_stop = 1; lap = 0; clear = 0; up_down_in = 0; live_number = '0;
        // Reset with start held: no edge on release.
        cycles(3);
        lv_rst = 0; cycles(3);
        lv_ss = 0; cycles(1);
        // Direction follows in IDLE.
        lv_ud = 1; cycles(2); lv_ud = 0; cycles(2); lv_ud = 1; cycles(1);
        // Start and run for a while; direction toggles are ignored.
        lv_ss = 1; cycles(1); lv_ss = 0; cycles(10);
        lv_ud = 0; cycles(11);
        // Pause a couple of cycles after a tick, then resume.
        lv_ss = 1; cycles(1); lv_ss = 0; cycles(1);
        lv_ss = 1; cycles(1); lv_ss = 0; cycles(6);
        press_start(); cycles(8);
        // Lap snapshot of a known value, then release.
        lv_live = 16'h0123; lv_lp = 1; cycles(1); lv_lp = 0; cycles(6);
        lv_lp = 1; cycles(1); lv_lp = 0; cycles(4);
        // Clear ignored in RUN, honoured in PAUSE.
        lv_cl = 1; cycles(1); lv_cl = 0; cycles(3);
        press_start();
        lv_cl = 1; cycles(1); lv_cl = 0; cycles(3);
        // Start again, pause, then start+clear together.
        press_start(); cycles(5); press_start();
        lv_ss = 1; lv_cl = 1; cycles(1); lv_ss = 0; lv_cl = 0; cycles(6);
        // Mid-run reset.
        lv_rst = 1; cycles(2); lv_rst = 0; cycles(3);
        // Randomized button activity.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) lv_ss = ~lv_ss;
            if ($urandom_range(0, 5) == 0) lv_lp = ~lv_lp;
            if ($urandom_range(0, 5) == 0) lv_cl = ~lv_cl;
            if ($urandom_range(0, 9) == 0) lv_ud = ~lv_ud;
            lv_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) lv_live = NW'($urandom);
            cycles(1);
        end
        lv_rst = 0; cycles(2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
